// File: rtl/calc_arbiter.sv
// Round-robin arbiter that shares one 4-bit calculator among N requesters.
// Divide-by-zero requests are answered directly without using the datapath.
module calc_arbiter #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    input  logic [2*N-1:0] req_op,
    input  logic [4*N-1:0] req_a,
    input  logic [4*N-1:0] req_b,
    output logic [N-1:0]   req_ready,
    output logic [N-1:0]   resp_valid,
    output logic [3:0]     resp_result,
    output logic           resp_carry,
    output logic           resp_err,
    output logic           calc_st,
    output logic [1:0]     calc_op,
    output logic [3:0]     calc_a,
    output logic [3:0]     calc_b,
    input  logic [3:0]     calc_result,
    input  logic           calc_carry
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] gnt_q, gnt_d;
    logic [1:0]    op_q, op_d;
    logic [3:0]    a_q, a_d;
    logic [3:0]    b_q, b_d;
    logic [3:0]    res_q, res_d;
    logic          carry_q, carry_d;
    logic          err_q, err_d;
    logic          st_q, st_d;
    logic [N-1:0]  rv_q, rv_d;

    logic          found;
    logic [PW-1:0] gsel;
    logic [PW:0]   cand;

    // First valid requester at or above ptr, wrapping modulo N.
    always_comb begin
        found = 1'b0;
        gsel  = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(k);
            if (cand >= (PW+1)'(N)) cand = cand - (PW+1)'(N);
            if (!found && req_valid[cand[PW-1:0]]) begin
                found = 1'b1;
                gsel  = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        carry_d   = carry_q;
        err_d     = err_q;
        req_ready = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready[gsel] = 1'b1;
                    gnt_d = gsel;
                    op_d  = req_op[2*int'(gsel) +: 2];
                    a_d   = req_a[4*int'(gsel) +: 4];
                    b_d   = req_b[4*int'(gsel) +: 4];
                    if (op_d == 2'b11 && b_d == 4'd0) begin
                        res_d   = 4'd0;
                        carry_d = 1'b0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: state_d = CAPTURE;
            CAPTURE: begin
                res_d   = calc_result;
                carry_d = calc_carry;
                err_d   = 1'b0;
                state_d = RESP;
            end
            RESP: begin
                ptr_d   = (gnt_q == PW'(N-1)) ? '0 : gnt_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) req_ready = '0;
    end

    // Strobes are registered from the next state so they line up with it.
    always_comb begin
        st_d = (state_d == ISSUE);
        rv_d = '0;
        if (state_d == RESP) rv_d[gnt_d] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            st_q    <= 1'b0;
            rv_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            err_q   <= err_d;
            st_q    <= st_d;
            rv_q    <= rv_d;
        end
    end

    assign resp_valid  = rv_q;
    assign resp_result = res_q;
    assign resp_carry  = carry_q;
    assign resp_err    = err_q;
    assign calc_st     = st_q;
    assign calc_op     = op_q;
    assign calc_a      = a_q;
    assign calc_b      = b_q;

endmodule

// File: tb/tb_calc_arbiter.sv
// Directed bench for calc_arbiter with a scoreboard of expected responses.
// A behavioural calculator answers calc_st one cycle later.
module tb_calc_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [2*N-1:0] req_op = '0;
    logic [4*N-1:0] req_a = '0;
    logic [4*N-1:0] req_b = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   resp_valid;
    logic [3:0]     resp_result;
    logic           resp_carry;
    logic           resp_err;
    logic           calc_st;
    logic [1:0]     calc_op;
    logic [3:0]     calc_a;
    logic [3:0]     calc_b;
    logic [3:0]     calc_result = '0;
    logic           calc_carry = 1'b0;

    always #5 clk = ~clk;

    calc_arbiter #(.N(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_result(resp_result), .resp_carry(resp_carry),
        .resp_err(resp_err), .calc_st(calc_st),
        .calc_op(calc_op), .calc_a(calc_a), .calc_b(calc_b),
        .calc_result(calc_result), .calc_carry(calc_carry)
    );

    typedef struct {
        int         owner;
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic       c;
        logic       e;
        int         hs;
    } exp_t;

    exp_t       sb[$];
    int         grants[$];
    int         gcyc[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc_n = 0;
    int         st_count = 0;
    int         last_st = -1;
    logic [N-1:0] persist = '0;

    // {err, carry, result[3:0]}
    function automatic logic [5:0] model(logic [1:0] op, logic [3:0] a, logic [3:0] b);
        logic [4:0] s;
        logic [7:0] p;
        case (op)
            2'b00: begin s = {1'b0, a} + {1'b0, b}; return {1'b0, s}; end
            2'b01: begin s = {1'b0, a} - {1'b0, b}; return {1'b0, s}; end
            2'b10: begin p = a * b; return {1'b0, p[4:0]}; end
            default: begin
                if (b == 4'd0) return 6'b100000;
                return {2'b00, a / b};
            end
        endcase
    endfunction

    logic [5:0] calc_m;
    assign calc_m = model(calc_op, calc_a, calc_b);

    always @(posedge clk) begin
        if (calc_st) begin
            calc_result <= calc_m[3:0];
            calc_carry  <= calc_m[4];
        end
    end

    function automatic int idx_of(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(int i, logic [1:0] op, logic [3:0] a, logic [3:0] b);
        req_op[2*i +: 2] = op;
        req_a[4*i +: 4]  = a;
        req_b[4*i +: 4]  = b;
        req_valid[i]     = 1'b1;
    endtask

    task automatic tick();
        logic [N-1:0] acc;
        logic [5:0]   m;
        int           g;
        exp_t         e;
        @(negedge clk);
        cyc_n++;
        acc = req_ready & req_valid;
        if (rst) begin
            chk("ready_in_reset", 32'(req_ready), 0);
            chk("st_in_reset", 32'(calc_st), 0);
        end
        if (req_ready != '0) begin
            chk("ready_onehot", 32'($onehot(req_ready) && acc == req_ready), 1);
            g = idx_of(req_ready);
            e.owner = g;
            e.op    = req_op[2*g +: 2];
            e.a     = req_a[4*g +: 4];
            e.b     = req_b[4*g +: 4];
            m       = model(e.op, e.a, e.b);
            e.res   = m[3:0];
            e.c     = m[4];
            e.e     = m[5];
            e.hs    = cyc_n;
            sb.push_back(e);
            grants.push_back(g);
            gcyc.push_back(cyc_n);
        end
        if (calc_st) begin
            st_count++;
            last_st = cyc_n;
            if (sb.size() == 0) begin
                chk("st_unexpected", 32'(calc_st), 0);
            end else begin
                chk("calc_fields", {22'b0, calc_op, calc_a, calc_b},
                    {22'b0, sb[0].op, sb[0].a, sb[0].b});
                chk("st_latency", cyc_n - sb[0].hs, 1);
            end
        end
        if (resp_valid != '0) begin
            if (sb.size() == 0) begin
                chk("resp_unexpected", 32'(resp_valid), 0);
            end else begin
                e = sb.pop_front();
                chk("resp_owner", 32'(resp_valid), 32'(1) << e.owner);
                chk("resp_data", {26'b0, resp_err, resp_carry, resp_result},
                    {26'b0, e.e, e.c, e.res});
                chk("resp_latency", cyc_n - e.hs, e.e ? 1 : 3);
            end
        end
        @(posedge clk);
        #1;
        req_valid = req_valid & ~(acc & ~persist);
    endtask

    task automatic wait_done(string tag, int budget);
        int n = 0;
        while ((sb.size() != 0 || req_valid != '0) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < budget), 1);
    endtask

    task automatic chk_outputs(string tag);
        @(negedge clk);
        cyc_n++;
        chk(tag, {7'b0, req_ready, resp_valid, resp_result, resp_carry,
                  resp_err, calc_st, calc_op, calc_a, calc_b}, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1);
    end

    initial begin
        int gb;
        int s0;
        int n;

        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        chk_outputs("reset_outputs");

        // Single add from requester 1
        drive(1, 2'b00, 4'd9, 4'd8);
        wait_done("t1_drain", 20);
        chk("t1_grant", grants[$], 1);
        chk("t1_st_cycle", last_st - gcyc[$], 1);
        chk("t1_result", {resp_err, resp_carry, resp_result}, 6'b010001);

        // All four valid out of reset
        rst = 1'b1;
        drive(0, 2'b00, 4'd5, 4'd6);
        drive(1, 2'b01, 4'd3, 4'd5);
        drive(2, 2'b10, 4'd15, 4'd15);
        drive(3, 2'b11, 4'd7, 4'd2);
        gb = grants.size();
        repeat (2) tick();
        rst = 1'b0;
        wait_done("rr_drain", 40);
        chk("rr_count", grants.size() - gb, 4);
        for (int k = 0; k < 4 && gb + k < grants.size(); k++) begin
            chk("rr_order", grants[gb+k], k);
            if (k > 0) chk("rr_spacing", gcyc[gb+k] - gcyc[gb+k-1], 4);
        end
        chk("div_7_2", {resp_err, resp_carry, resp_result}, 6'b000011);

        // Wrap-around: ptr back at 0 after granting 3
        gb = grants.size();
        drive(3, 2'b01, 4'd5, 4'd5);
        drive(0, 2'b00, 4'd15, 4'd1);
        wait_done("wrap_drain", 30);
        chk("wrap_count", grants.size() - gb, 2);
        if (grants.size() - gb == 2) begin
            chk("wrap_first", grants[gb], 0);
            chk("wrap_second", grants[gb+1], 3);
        end

        // Fairness with 0 and 2 held valid
        persist = 4'b0101;
        drive(0, 2'b10, 4'd4, 4'd5);
        drive(2, 2'b00, 4'd2, 4'd3);
        gb = grants.size();
        n = 0;
        while (grants.size() - gb < 4 && n < 40) begin
            tick();
            n++;
        end
        req_valid = '0;
        persist = '0;
        chk("fair_budget", 32'(n < 40), 1);
        wait_done("fair_drain", 20);
        for (int k = 0; k < 4 && gb + k < grants.size(); k++) begin
            chk("fair_order", grants[gb+k], (k % 2) * 2);
            if (k > 0) chk("fair_no_repeat", 32'(grants[gb+k] == grants[gb+k-1]), 0);
        end

        // Divide by zero, then a real divide
        s0 = st_count;
        gb = grants.size();
        drive(3, 2'b11, 4'd7, 4'd0);
        wait_done("dz_drain", 10);
        chk("dz_grant", grants[$], 3);
        chk("dz_no_st", st_count - s0, 0);
        chk("dz_resp", {resp_err, resp_carry, resp_result}, 6'b100000);
        drive(3, 2'b11, 4'd7, 4'd2);
        wait_done("div_drain", 20);
        chk("div_st", st_count - s0, 1);
        chk("div_resp", {resp_err, resp_carry, resp_result}, 6'b000011);

        // Borrow and truncated product
        drive(1, 2'b01, 4'd3, 4'd5);
        wait_done("sub_drain", 20);
        chk("sub_borrow", {resp_err, resp_carry, resp_result}, 6'b011110);
        drive(2, 2'b10, 4'd15, 4'd15);
        wait_done("mul_drain", 20);
        chk("mul_trunc", {resp_err, resp_carry, resp_result}, 6'b000001);

        // Reset while in CAPTURE
        drive(3, 2'b00, 4'd1, 4'd1);
        gb = grants.size();
        n = 0;
        while (grants.size() == gb && n < 10) begin
            tick();
            n++;
        end
        chk("rc_grant_budget", 32'(n < 10), 1);
        tick();
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0;
        req_valid = '0;
        chk_outputs("post_reset_outputs");
        repeat (4) tick();

        // Pointer restarts at 0: 2 beats 3
        gb = grants.size();
        drive(3, 2'b00, 4'd2, 4'd2);
        drive(2, 2'b01, 4'd9, 4'd1);
        wait_done("ptr_drain", 30);
        chk("ptr_count", grants.size() - gb, 2);
        if (grants.size() - gb == 2) begin
            chk("ptr_first", grants[gb], 2);
            chk("ptr_second", grants[gb+1], 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/calc_arbiter.md
# calc_arbiter

Round-robin arbiter and sequencer that shares one 4-bit calculator datapath among N requesters. It accepts one operation at a time over a valid/ready handshake and drives the calculator's start, op and operand inputs. It captures the registered result and carry, then returns them to the winning requester as a one-cycle response. Divide-by-zero requests are detected and answered without being issued to the datapath.

## Interface
- N, default 4: number of requesters (2..8).
- clk  in  1  rising-edge clock for all state.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  N  per-requester request valid.
- req_op  in  2N  op for requester i at [2i+1:2i]: 00 add, 01 sub, 10 mul, 11 div.
- req_a  in  4N  operand a for requester i at [4i+3:4i].
- req_b  in  4N  operand b for requester i at [4i+3:4i].
- req_ready  out  N  one-hot; accept strobe for the granted requester.
- resp_valid  out  N  one-hot, one-cycle response pulse to the owning requester.
- resp_result  out  4  result for the current response; held until the next response.
- resp_carry  out  1  carry for the current response; held until the next response.
- resp_err  out  1  1 = divide by zero; held until the next response.
- calc_st  out  1  start strobe to the calculator.
- calc_op  out  2  op to the calculator.
- calc_a  out  4  operand a to the calculator.
- calc_b  out  4  operand b to the calculator.
- calc_result  in  4  registered result from the calculator.
- calc_carry  in  1  registered carry from the calculator.

## Operation
- States: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - Grant g is the first i with req_valid[i] set, searching from ptr upward modulo N.
  - req_ready[g]=1 combinationally; the handshake completes this cycle.
  - Latch op, a, b and g.
  - If op==11 and b==0, go to RESP with err=1, result=0, carry=0.
  - Otherwise go to ISSUE.
  - With no valid request, stay in IDLE with req_ready=0.
- ISSUE: calc_st=1 for exactly this cycle. Go to CAPTURE.
- CAPTURE: calc_result and calc_carry hold the new value. Latch them into resp_result and resp_carry, set err=0, go to RESP.
- RESP:
  - resp_valid[g]=1 for one cycle.
  - ptr <= (g+1) mod N.
  - Go to IDLE.
- calc_op, calc_a and calc_b are always driven from the latched registers. They are stable from ISSUE through CAPTURE.
- calc_st=0 in every state except ISSUE.
- req_ready=0 in every state except IDLE.
- The arbiter does not alter result or carry. Carry semantics are those of the datapath:
  - add: bit 4 of the sum.
  - sub: bit 4 of the 5-bit difference (borrow).
  - mul: bit 4 of the product (truncated).
  - div: 0.
- A requester must hold req_valid and its fields until req_ready. Dropping req_valid before grant is legal; no operation is recorded.

## Timing
- Reset values:
  - state=IDLE, ptr=0.
  - req_ready=0, resp_valid=0, resp_result=0, resp_carry=0, resp_err=0.
  - calc_st=0, calc_op=0, calc_a=0, calc_b=0.
- Normal latency: handshake in cycle T, calc_st in T+1, capture in T+2, resp_valid in T+3.
- Divide-by-zero latency: handshake in cycle T, resp_valid in T+1. No calc_st is issued.
- Throughput: at most one request per 4 cycles (per 2 cycles for divide-by-zero).
- The earliest next grant is the cycle after RESP. New requests arriving during ISSUE, CAPTURE or RESP wait.
- Simultaneous requests: the lowest index at or above ptr wins; the rest wait. After a grant, the granted index has lowest priority.
- Wrap-around: g=N-1 sets ptr=0.
- Reset mid-operation: return to IDLE next cycle with reset values and no response pulse. calc_st=0 during the reset cycle. The calculator's own reset is separate.

## Test plan
- Single request: requester 1, add a=9 b=8. Expected: req_ready[1] in T; calc_st in T+1; resp_valid=0010 in T+3; result=1, carry=1, err=0.
- All four requesters valid from reset with distinct ops. Expected: grants in order 0,1,2,3, each 4 cycles apart. After the grant to 3, ptr=0.
- Fairness: requesters 0 and 2 valid continuously. Expected: grants alternate 0,2,0,2; neither is granted twice in a row.
- Divide by zero: requester 3, op=11 a=7 b=0. Expected: resp_valid=1000 at T+1; err=1, result=0, calc_st never asserted. Then a divide with a=7 b=2 gives result=3, carry=0, err=0.
- Subtract borrow and multiply overflow:
  - sub a=3 b=5: result=14, carry=1.
  - mul a=15 b=15: result=1, carry=0 (product 225 truncated to 5 bits = 1).
- Reset asserted in CAPTURE. Expected: no resp_valid; all outputs at reset values next cycle. A post-reset request from requester 2 is granted first with ptr=0.
